// File: rtl/traffic_cfg_scheduler.sv
// Round-robin command scheduler for the traffic light controller command port.
// Each granted request is expanded into its legal command sequence and issued one command at a time.
module traffic_cfg_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int CMD_GAP = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic [NUM_REQ-1:0]                          req_valid_i,
    output logic [NUM_REQ-1:0]                          req_ready_o,
    input  logic [2*NUM_REQ-1:0]                        req_op_i,
    input  logic [16*NUM_REQ-1:0]                       req_green_i,
    input  logic [16*NUM_REQ-1:0]                       req_red_i,
    input  logic [16*NUM_REQ-1:0]                       req_yellow_i,
    output logic [2:0]                                  cmd_type_o,
    output logic                                        cmd_valid_o,
    output logic [15:0]                                 cmd_data_o,
    output logic                                        busy_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id_o
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW  = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);

    localparam logic [1:0] OP_CONFIG = 2'd0;
    localparam logic [1:0] OP_OFF    = 2'd1;
    localparam logic [1:0] OP_ON     = 2'd2;

    localparam logic [2:0] C_ON     = 3'd0;
    localparam logic [2:0] C_OFF    = 3'd1;
    localparam logic [2:0] C_MANUAL = 3'd2;
    localparam logic [2:0] C_SETG   = 3'd3;
    localparam logic [2:0] C_SETR   = 3'd4;
    localparam logic [2:0] C_SETY   = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_ptr, r_grant;
    logic             r_busy, w_busy_nxt;
    logic             r_cmd_valid, w_valid_nxt;
    logic [2:0]       r_cmd_type, w_type_nxt;
    logic [15:0]      r_cmd_data, w_data_nxt;
    logic [1:0]       r_op;
    logic [15:0]      r_green, r_red, r_yellow;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [GW-1:0]    r_cnt, w_cnt_nxt;

    logic             w_found, w_hs, w_more;
    logic [IDW-1:0]   w_win, w_ptr_nxt;
    logic [1:0]       w_sel_op;
    logic [2:0]       w_next_type;
    logic [15:0]      w_next_data;

    // Command list entry idx for a captured op; CONFIG wraps the SET_* in MANUAL ... ON.
    function automatic logic [2:0] entry_type(input logic [1:0] op, input logic [2:0] idx);
        if (op == OP_CONFIG) begin
            case (idx)
                3'd0:    return C_MANUAL;
                3'd1:    return C_SETG;
                3'd2:    return C_SETR;
                3'd3:    return C_SETY;
                default: return C_ON;
            endcase
        end
        if (op == OP_OFF) return C_OFF;
        if (op == OP_ON)  return C_ON;
        return C_MANUAL;
    endfunction

    // Downstream counts to value-1, so a zero time would wrap to 65535.
    function automatic logic [15:0] clamp(input logic [15:0] t);
        return (t == 16'd0) ? 16'd1 : t;
    endfunction

    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && req_valid_i[j]) begin
                w_found = 1'b1;
                w_win   = j[IDW-1:0];
            end
        end
    end

    assign w_hs      = (r_state == S_IDLE) && w_found;
    assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
    assign w_sel_op  = req_op_i[2*w_win +: 2];

    // Reset gating keeps ready low while reset is asserted even with requests pending.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready_o[i] = w_hs && rst_n_i && (int'(w_win) == i);
    end

    assign w_more      = (r_idx + 3'd1) < ((r_op == OP_CONFIG) ? 3'd5 : 3'd1);
    assign w_next_type = entry_type(r_op, r_idx + 3'd1);

    always_comb begin
        case (w_next_type)
            C_SETG:  w_next_data = r_green;
            C_SETR:  w_next_data = r_red;
            C_SETY:  w_next_data = r_yellow;
            default: w_next_data = 16'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_valid_nxt = 1'b0;
        w_type_nxt  = 3'd0;
        w_data_nxt  = 16'd0;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_ISSUE;
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = 3'd0;
                    w_valid_nxt = 1'b1;
                    w_type_nxt  = entry_type(w_sel_op, 3'd0);
                end
            end
            S_ISSUE: begin
                if (CMD_GAP > 0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_INIT;
                end else if (w_more) begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_valid_nxt = 1'b1;
                    w_type_nxt  = w_next_type;
                    w_data_nxt  = w_next_data;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_more) begin
                    w_state_nxt = S_ISSUE;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_valid_nxt = 1'b1;
                    w_type_nxt  = w_next_type;
                    w_data_nxt  = w_next_data;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= 3'd0;
            r_cmd_data  <= 16'd0;
            r_op        <= 2'd0;
            r_green     <= 16'd0;
            r_red       <= 16'd0;
            r_yellow    <= 16'd0;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_cmd_valid <= w_valid_nxt;
            r_cmd_type  <= w_type_nxt;
            r_cmd_data  <= w_data_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_hs) begin
                r_ptr    <= w_ptr_nxt;
                r_grant  <= w_win;
                r_op     <= w_sel_op;
                r_green  <= clamp(req_green_i[16*w_win +: 16]);
                r_red    <= clamp(req_red_i[16*w_win +: 16]);
                r_yellow <= clamp(req_yellow_i[16*w_win +: 16]);
            end
        end
    end

    assign cmd_valid_o = r_cmd_valid;
    assign cmd_type_o  = r_cmd_type;
    assign cmd_data_o  = r_cmd_data;
    assign busy_o      = r_busy;
    assign grant_id_o  = r_grant;
endmodule
